cache_mem_bridge: RTL and testbench

Memory-side stage directly downstream of the 4-way/4-word cache. It accepts 128-bit line read/write requests from the cache master port and serialises them into 32-bit word beats on a pipelined single-word memory bus. It then reassembles read beats into a full line and returns it to the cache. It owns all beat sequencing, so the cache sees a line-wide port with a simple waitrequest handshake.

---
 rtl/cache_pkg.sv | 45 ++++
 rtl/cache_line_assembler.sv | 47 ++++
 rtl/cache_mem_bridge.sv | 123 ++++++++++++
 tb/tb_cache_mem_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache memory-side bridge.
// Line/beat geometry, FSM states and word-slice utilities.
package cache_pkg;

  localparam int ADDR_W  = 26;
  localparam int WORD_W  = 32;
  localparam int BEATS   = 4;
  localparam int LINE_W  = WORD_W * BEATS;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int WADDR_W = ADDR_W + BEAT_W;

  typedef logic [BEAT_W:0] cnt_t;

  localparam cnt_t BEAT_END = cnt_t'(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RESP
  } state_t;

  function automatic logic [WORD_W-1:0] word_of(
    input logic [LINE_W-1:0] line,
    input logic [BEAT_W-1:0] k
  );
    return line[WORD_W*int'(k) +: WORD_W];
  endfunction

  // Lowest enabled word index >= from, or BEAT_END if none remain.
  function automatic cnt_t next_beat(
    input logic [BEATS-1:0] mask,
    input cnt_t             from
  );
    cnt_t r;
    r = BEAT_END;
    for (int k = BEATS - 1; k >= 0; k--) begin
      if (mask[k] && cnt_t'(k) >= from) begin
        r = cnt_t'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_line_assembler.sv
// Collects in-order read beats into a line buffer.
// Exposes the merged next-line so the caller can capture on the last beat.
module cache_line_assembler
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  output logic [LINE_W-1:0] line_nxt,
  output logic              done
);

  cnt_t              ret_q, ret_d;
  logic [LINE_W-1:0] buf_q, buf_d;

  always_comb begin
    ret_d = ret_q;
    buf_d = buf_q;
    done  = 1'b0;
    if (clr) begin
      ret_d = '0;
    end else if (en) begin
      for (int k = 0; k < BEATS; k++) begin
        if (ret_q[BEAT_W-1:0] == BEAT_W'(k)) begin
          buf_d[k*WORD_W +: WORD_W] = word;
        end
      end
      ret_d = ret_q + 1'b1;
      done  = (ret_q == BEAT_END - 1'b1);
    end
  end

  assign line_nxt = buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= '0;
      buf_q <= '0;
    end else begin
      ret_q <= ret_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// Serialises 128-bit cache line requests into 32-bit memory beats
// and reassembles read beats into a line for the cache.
module cache_mem_bridge
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  i_c_addr,
  input  logic [BEATS-1:0]   i_c_byte_en,
  input  logic [LINE_W-1:0]  i_c_writedata,
  input  logic               i_c_read,
  input  logic               i_c_write,
  output logic [LINE_W-1:0]  o_c_readdata,
  output logic               o_c_readdata_valid,
  output logic               o_c_waitrequest,
  output logic [WADDR_W-1:0] o_w_addr,
  output logic [WORD_W-1:0]  o_w_writedata,
  output logic               o_w_read,
  output logic               o_w_write,
  input  logic [WORD_W-1:0]  i_w_readdata,
  input  logic               i_w_readdata_valid,
  input  logic               i_w_waitrequest
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEATS-1:0]  be_q, be_d;
  logic [LINE_W-1:0] wd_q, wd_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  cnt_t              ptr_q, ptr_d;
  cnt_t              nxt;
  logic              asm_done;
  logic [LINE_W-1:0] asm_line;

  cache_line_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q != RD),
    .en       (i_w_readdata_valid),
    .word     (i_w_readdata),
    .line_nxt (asm_line),
    .done     (asm_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    nxt     = next_beat(be_q, ptr_q + 1'b1);
    unique case (state_q)
      IDLE: begin
        if (i_c_write || i_c_read) begin
          addr_d = i_c_addr;
          be_d   = i_c_byte_en;
          wd_d   = i_c_writedata;
        end
        // Write wins over a simultaneous read.
        if (i_c_write) begin
          ptr_d   = next_beat(i_c_byte_en, '0);
          state_d = WR;
        end else if (i_c_read) begin
          ptr_d   = '0;
          state_d = RD;
        end
      end
      WR: begin
        if (ptr_q == BEAT_END) begin
          state_d = IDLE;
        end else if (!i_w_waitrequest) begin
          ptr_d = nxt;
          if (nxt == BEAT_END) begin
            state_d = IDLE;
          end
        end
      end
      RD: begin
        if (!ptr_q[BEAT_W] && !i_w_waitrequest) begin
          ptr_d = ptr_q + 1'b1;
        end
        if (asm_done) begin
          rdata_d = asm_line;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_c_waitrequest    = (state_q != IDLE);
  assign o_c_readdata_valid = (state_q == RESP);
  assign o_c_readdata       = rdata_q;
  assign o_w_write     = (state_q == WR) && !ptr_q[BEAT_W];
  assign o_w_read      = (state_q == RD) && !ptr_q[BEAT_W];
  assign o_w_addr      = {addr_q, ptr_q[BEAT_W-1:0]};
  assign o_w_writedata = word_of(wd_q, ptr_q[BEAT_W-1:0]);

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge with a word-memory responder.
// Table of line transactions plus timing, stall and reset sequences.
module tb_cache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [25:0]  i_c_addr;
  logic [3:0]   i_c_byte_en;
  logic [127:0] i_c_writedata;
  logic         i_c_read;
  logic         i_c_write;
  logic [127:0] o_c_readdata;
  logic         o_c_readdata_valid;
  logic         o_c_waitrequest;
  logic [27:0]  o_w_addr;
  logic [31:0]  o_w_writedata;
  logic         o_w_read;
  logic         o_w_write;
  logic [31:0]  i_w_readdata = '0;
  logic         i_w_readdata_valid = 1'b0;
  logic         i_w_waitrequest = 1'b0;

  cache_mem_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .i_c_addr           (i_c_addr),
    .i_c_byte_en        (i_c_byte_en),
    .i_c_writedata      (i_c_writedata),
    .i_c_read           (i_c_read),
    .i_c_write          (i_c_write),
    .o_c_readdata       (o_c_readdata),
    .o_c_readdata_valid (o_c_readdata_valid),
    .o_c_waitrequest    (o_c_waitrequest),
    .o_w_addr           (o_w_addr),
    .o_w_writedata      (o_w_writedata),
    .o_w_read           (o_w_read),
    .o_w_write          (o_w_write),
    .i_w_readdata       (i_w_readdata),
    .i_w_readdata_valid (i_w_readdata_valid),
    .i_w_waitrequest    (i_w_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          due;
  } ret_t;

  typedef struct {
    logic [27:0] a;
    logic [31:0] d;
    int          c;
  } log_t;

  logic [31:0] mem [logic [27:0]];
  ret_t        rq[$];
  log_t        rlog[$];
  log_t        wlog[$];
  int          cyc = 0;
  int          lat = 1;
  logic [1:0]  stall_beat = 2'd0;
  int          stall_left = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [27:0] prev_addr = '0;
  int          vcount = 0;
  int          vcyc = 0;
  logic [127:0] cap_line = '0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdmem(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (prev_stall && (!o_w_read || o_w_addr != prev_addr))
      stall_err++;
    i_w_waitrequest = 1'b0;
    if (o_w_read && o_w_addr[1:0] == stall_beat && stall_left > 0) begin
      i_w_waitrequest = 1'b1;
      stall_left--;
    end
    prev_stall = i_w_waitrequest && o_w_read;
    prev_addr  = o_w_addr;
    if (o_w_read && !i_w_waitrequest) begin
      rq.push_back('{rdmem(o_w_addr), cyc + lat});
      rlog.push_back('{o_w_addr, 32'h0, cyc});
    end
    if (o_w_write && !i_w_waitrequest) begin
      mem[o_w_addr] = o_w_writedata;
      wlog.push_back('{o_w_addr, o_w_writedata, cyc});
    end
    i_w_readdata_valid = 1'b0;
    i_w_readdata = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      i_w_readdata_valid = 1'b1;
      i_w_readdata = rq[0].d;
      void'(rq.pop_front());
    end
    if (o_c_readdata_valid) begin
      vcount++;
      cap_line = o_c_readdata;
      vcyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  int nv_base;

  task automatic run_txn(input bit rd, input bit wr,
                         input logic [25:0] a, input logic [3:0] be,
                         input logic [127:0] wd,
                         output int busy, output int t0);
    @(negedge clk);
    wlog.delete();
    rlog.delete();
    nv_base = vcount;
    i_c_read = rd;
    i_c_write = wr;
    i_c_addr = a;
    i_c_byte_en = be;
    i_c_writedata = wd;
    t0 = cyc;
    @(negedge clk);
    i_c_read = 1'b0;
    i_c_write = 1'b0;
    busy = 0;
    while (o_c_waitrequest && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    if (busy >= 200) chk("busy_timeout", 1, 0);
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [25:0]  addr;
    logic [3:0]   be;
    logic [127:0] wd;
    int           busy;
    int           nwr;
    int           nrd;
    int           nval;
    logic [127:0] line;
    logic [27:0]  fwa;
    logic [31:0]  fwd;
    logic [27:0]  lwa;
    logic [31:0]  lwd;
  } vec_t;

  vec_t v[8];

  initial begin
    int busy, t0, w;
    logic [127:0] last;
    rst = 1'b1;
    i_c_addr = '0;
    i_c_byte_en = '0;
    i_c_writedata = '0;
    i_c_read = 1'b0;
    i_c_write = 1'b0;
    mem[28'h48] = 32'hA;
    mem[28'h49] = 32'hB;
    mem[28'h4A] = 32'hC;
    mem[28'h4B] = 32'hD;

    v[0] = '{1, 0, 26'h12, 4'h0, '0, 6, 0, 4, 1,
             {32'hD, 32'hC, 32'hB, 32'hA}, 0, 0, 0, 0};
    v[1] = '{0, 1, 26'h3, 4'b1010, {32'd4, 32'd3, 32'd2, 32'd1},
             2, 2, 0, 0, '0, 28'h0D, 32'd2, 28'h0F, 32'd4};
    v[2] = '{1, 0, 26'h3, 4'h0, '0, 6, 0, 4, 1,
             {32'd4, 32'hC0DE000E, 32'd2, 32'hC0DE000C}, 0, 0, 0, 0};
    v[3] = '{0, 1, 26'h7, 4'h0, {4{32'hFFFF}}, 1, 0, 0, 0,
             '0, 0, 0, 0, 0};
    v[4] = '{1, 1, 26'h5, 4'hF,
             {32'h44, 32'h33, 32'h22, 32'h11}, 4, 4, 0, 0, '0,
             28'h14, 32'h11, 28'h17, 32'h44};
    v[5] = '{1, 0, 26'h5, 4'h0, '0, 6, 0, 4, 1,
             {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 0, 0};
    v[6] = '{0, 1, 26'h3FFFFFF, 4'b1000,
             {32'hDEADBEEF, 32'h3, 32'h2, 32'h1}, 1, 1, 0, 0, '0,
             28'hFFFFFFF, 32'hDEADBEEF, 28'hFFFFFFF, 32'hDEADBEEF};
    v[7] = '{1, 0, 26'h3FFFFFF, 4'h0, '0, 6, 0, 4, 1,
             {32'hDEADBEEF, 32'hC0DEFFFE, 32'hC0DEFFFD,
              32'hC0DEFFFC}, 0, 0, 0, 0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_wait", o_c_waitrequest, 0);
    chk("rst_valid", o_c_readdata_valid, 0);
    chk("rst_rd", o_w_read, 0);
    chk("rst_wr", o_w_write, 0);
    chk("rst_addr", o_w_addr, 0);
    chk("rst_wdata", o_w_writedata, 0);
    chk("rst_rdata", o_c_readdata, 0);
    rst = 1'b0;

    // Zero-wait read timing.
    run_txn(1, 0, 26'h12, 4'h0, '0, busy, t0);
    chk("a_busy", busy, 6);
    chk("a_nrd", rlog.size(), 4);
    if (rlog.size() == 4) begin
      chk("a_iss0_cyc", rlog[0].c - t0, 1);
      chk("a_iss3_cyc", rlog[3].c - t0, 4);
      chk("a_iss0_addr", rlog[0].a, 28'h48);
      chk("a_iss3_addr", rlog[3].a, 28'h4B);
    end
    chk("a_vcyc", vcyc - t0, 6);
    chk("a_nval", vcount - nv_base, 1);
    chk("a_line", cap_line, {32'hD, 32'hC, 32'hB, 32'hA});
    last = cap_line;

    for (int i = 0; i < 8; i++) begin
      run_txn(v[i].rd, v[i].wr, v[i].addr, v[i].be, v[i].wd,
              busy, t0);
      chk($sformatf("v%0d_busy", i), busy, v[i].busy);
      chk($sformatf("v%0d_nwr", i), wlog.size(), v[i].nwr);
      chk($sformatf("v%0d_nrd", i), rlog.size(), v[i].nrd);
      chk($sformatf("v%0d_nval", i), vcount - nv_base, v[i].nval);
      if (v[i].rd && !v[i].wr) begin
        chk($sformatf("v%0d_line", i), cap_line, v[i].line);
        last = v[i].line;
      end else begin
        chk($sformatf("v%0d_hold", i), o_c_readdata, last);
      end
      w = wlog.size();
      if (v[i].nwr > 0 && w > 0) begin
        chk($sformatf("v%0d_fwa", i), wlog[0].a, v[i].fwa);
        chk($sformatf("v%0d_fwd", i), wlog[0].d, v[i].fwd);
        chk($sformatf("v%0d_lwa", i), wlog[w-1].a, v[i].lwa);
        chk($sformatf("v%0d_lwd", i), wlog[w-1].d, v[i].lwd);
      end
    end

    // Stall beat 2 for 3 cycles, returns 3 cycles after issue.
    lat = 3;
    stall_beat = 2'd2;
    stall_left = 3;
    stall_err = 0;
    run_txn(1, 0, 26'h12, 4'h0, '0, busy, t0);
    chk("s_busy", busy, 11);
    chk("s_stall_used", stall_left, 0);
    chk("s_addr_stable", stall_err, 0);
    chk("s_nval", vcount - nv_base, 1);
    chk("s_line", cap_line, {32'hD, 32'hC, 32'hB, 32'hA});
    chk("s_nrd", rlog.size(), 4);
    if (rlog.size() == 4) chk("s_iss2_cyc", rlog[2].c - t0, 6);
    lat = 1;

    // Reset after the second return.
    @(negedge clk);
    nv_base = vcount;
    i_c_read = 1'b1;
    i_c_addr = 26'h12;
    t0 = cyc;
    @(negedge clk);
    i_c_read = 1'b0;
    busy = 0;
    while (cyc != t0 + 4 && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    chk("r_reached", cyc - t0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_rd", o_w_read, 0);
    chk("r_wr", o_w_write, 0);
    chk("r_wait", o_c_waitrequest, 0);
    repeat (6) @(negedge clk);
    chk("r_nval", vcount - nv_base, 0);
    chk("r_rdata", o_c_readdata, 0);
    chk("r_idle", o_c_waitrequest, 0);

    run_txn(1, 0, 26'h5, 4'h0, '0, busy, t0);
    chk("x_busy", busy, 6);
    chk("x_line", cap_line, {32'h44, 32'h33, 32'h22, 32'h11});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
